// File: rtl/vc_domain_queue_pkg.sv
// rtl/vc_domain_queue_pkg.sv - domain encodings and width helper for the domain-tagged queue
package vc_domain_queue_pkg;

  // Security-domain tag encodings carried alongside each payload
  localparam logic DOMAIN_L = 1'b0;
  localparam logic DOMAIN_H = 1'b1;

  // Ceiling log2, used for pointer and occupancy-count widths
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/vc_domain_queue_ctrl.sv
// rtl/vc_domain_queue_ctrl.sv - pointers, occupancy, per-slot valid bits, scrub and bubble retire
module vc_domain_queue_ctrl
  import vc_domain_queue_pkg::*;
#(
  parameter int p_num_entries = 4,
  localparam int c_ptr_w = clog2(p_num_entries),
  localparam int c_cnt_w = c_ptr_w + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_val,
  output logic                     enq_rdy,
  output logic                     enq_fire,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  input  logic                     scrub,
  input  logic                     scrub_domain,
  input  logic [p_num_entries-1:0] slot_domain,
  output logic [c_ptr_w-1:0]       enq_ptr,
  output logic [c_ptr_w-1:0]       deq_ptr,
  output logic [c_cnt_w-1:0]       num_free
);

  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(p_num_entries);

  logic [c_cnt_w-1:0]       count;
  logic [p_num_entries-1:0] valid;
  logic [p_num_entries-1:0] valid_next;
  logic                     not_empty;
  logic                     not_full;
  logic                     head_valid;
  logic                     deq_fire;
  logic                     bubble;
  logic                     retire;

  // Handshake and retire decisions come from registered state only
  assign not_empty  = (count != '0);
  assign not_full   = (count != c_full);
  assign head_valid = valid[deq_ptr];
  assign enq_rdy    = not_full & ~reset;
  assign deq_val    = not_empty & head_valid;
  assign enq_fire   = enq_val & enq_rdy;
  assign deq_fire   = deq_val & deq_rdy;
  assign bubble     = not_empty & ~head_valid;
  assign retire     = deq_fire | bubble;
  assign num_free   = c_full - count;

  // Next valid bits: retire clears the head, scrub clears matching stored slots,
  // and a same-cycle enqueue sets its slot last so it is never scrubbed
  always_comb begin
    valid_next = valid;
    for (int i = 0; i < p_num_entries; i++) begin
      if (retire && (deq_ptr == c_ptr_w'(i))) valid_next[i] = 1'b0;
      if (scrub && (slot_domain[i] == scrub_domain)) valid_next[i] = 1'b0;
      if (enq_fire && (enq_ptr == c_ptr_w'(i))) valid_next[i] = 1'b1;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else begin
      if (enq_fire) enq_ptr <= enq_ptr + c_ptr_w'(1);
      if (retire)   deq_ptr <= deq_ptr + c_ptr_w'(1);
      count <= count + c_cnt_w'(enq_fire) - c_cnt_w'(retire);
    end
  end

  // Per-slot valid register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid <= '0;
    else       valid <= valid_next;
  end

endmodule

// File: rtl/vc_domain_queue.sv
// rtl/vc_domain_queue.sv - val/rdy queue with per-entry security-domain tag and single-cycle domain scrub
module vc_domain_queue
  import vc_domain_queue_pkg::*;
#(
  parameter int p_nbits       = 32,
  parameter int p_num_entries = 4,
  localparam int c_ptr_w = clog2(p_num_entries),
  localparam int c_cnt_w = c_ptr_w + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  input  logic               enq_domain,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic               deq_domain,
  input  logic               scrub,
  input  logic               scrub_domain,
  output logic [c_cnt_w-1:0] num_free
);

  logic [p_nbits-1:0]       slot_msg [p_num_entries];
  logic [p_num_entries-1:0] slot_dom;
  logic [c_ptr_w-1:0]       enq_ptr;
  logic [c_ptr_w-1:0]       deq_ptr;
  logic                     enq_fire;

  vc_domain_queue_ctrl #(
    .p_num_entries (p_num_entries)
  ) ctrl (
    .clk          (clk),
    .reset        (reset),
    .enq_val      (enq_val),
    .enq_rdy      (enq_rdy),
    .enq_fire     (enq_fire),
    .deq_val      (deq_val),
    .deq_rdy      (deq_rdy),
    .scrub        (scrub),
    .scrub_domain (scrub_domain),
    .slot_domain  (slot_dom),
    .enq_ptr      (enq_ptr),
    .deq_ptr      (deq_ptr),
    .num_free     (num_free)
  );

  // Payload and domain storage, written only on an accepted enqueue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < p_num_entries; i++) begin
        slot_msg[i] <= '0;
        slot_dom[i] <= DOMAIN_L;
      end
    end else if (enq_fire) begin
      slot_msg[enq_ptr] <= enq_msg;
      slot_dom[enq_ptr] <= enq_domain;
    end
  end

  // Head read mux, driven regardless of deq_val
  assign deq_msg    = slot_msg[deq_ptr];
  assign deq_domain = slot_dom[deq_ptr];

endmodule
